// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Optional auto-repeat is enabled with KEYPAD_REPEAT_EN.
package keypad_pkg;

  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } scan_res_t;

  function automatic logic [3:0] key_map(
    input logic [1:0] c,
    input logic [1:0] r
  );
    logic [15:0][3:0] tbl;
    // Index is {col,row}; entry 0 is col0/row0
    tbl = {4'hD, 4'hC, 4'hB, 4'hA,
           4'hE, 4'h9, 4'h6, 4'h3,
           4'hF, 4'h8, 4'h5, 4'h2,
           4'h0, 4'h7, 4'h4, 4'h1};
    return tbl[{c, r}];
  endfunction

endpackage

// File: rtl/keypad_scanner_debounce.sv
// Scan-result debouncer: owns the stable count, release rule, dec and button_pressed.
// Auto-repeat logic exists only when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_done,
  input  scan_res_t  res,
  output logic [3:0] dec,
  output logic       button_pressed
);

  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] DB = SW'(DEBOUNCE_SCANS);

  scan_res_t     prev_q, prev_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [3:0]    dec_q, dec_d;
  logic          bp_q, bp_d;
  logic          same, becomes, held_ok;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep_q, rep_d;
  logic          gap_q, gap_d;
`endif

  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    dec_d    = dec_q;
    bp_d     = bp_q;
    same     = (res == prev_q);
    becomes  = 1'b0;
    held_ok  = res.valid && (res.code == dec_q);
`ifdef KEYPAD_REPEAT_EN
    rep_d    = rep_q;
    gap_d    = gap_q;
`endif
    if (scan_done) begin
      prev_d = res;
      if (!same)
        stable_d = SW'(1);
      else if (stable_q != DB)
        stable_d = stable_q + SW'(1);
      becomes = (stable_d == DB) && !(same && stable_q == DB);
`ifdef KEYPAD_REPEAT_EN
      if (gap_q) begin
        gap_d = 1'b0;
        bp_d  = held_ok;
        rep_d = '0;
      end else if (bp_q) begin
        if (!held_ok) begin
          rep_d = '0;
        end else if (rep_q == RW'(REPEAT_SCANS - 1)) begin
          bp_d  = 1'b0;
          gap_d = 1'b1;
          rep_d = '0;
        end else begin
          rep_d = rep_q + RW'(1);
        end
      end
`endif
      if (becomes) begin
        if (!res.valid) begin
          bp_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
          gap_d = 1'b0;
`endif
        end else if (!bp_q) begin
          dec_d = res.code;
          bp_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
          gap_d = 1'b0;
          rep_d = '0;
`endif
        end else if (!held_ok) begin
          // New key while held: release first, then re-qualify
          bp_d     = 1'b0;
          stable_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      stable_q <= '0;
      dec_q    <= 4'h0;
      bp_q     <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      stable_q <= stable_d;
      dec_q    <= dec_d;
      bp_q     <= bp_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
      gap_q <= 1'b0;
    end else begin
      rep_q <= rep_d;
      gap_q <= gap_d;
    end
  end
`endif

  assign dec            = dec_q;
  assign button_pressed = bp_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row sync, column drive and per-scan hit collection.
// Auto-repeat in the debouncer is enabled with KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned COL_CYCLES     = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] dec,
  output logic       button_pressed
);

  localparam int CW = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [1:0]    cidx_q, cidx_d;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    code_q, code_d;
  logic          sample, scan_done;
  logic [2:0]    col_hits, sum;
  logic [1:0]    hits_new, row_first;
  logic [3:0]    code_new;
  scan_res_t     res;

  always_comb begin
    sample    = (cyc_q == CW'(COL_CYCLES - 1));
    scan_done = sample && (cidx_q == 2'd3);
    cyc_d     = sample ? '0 : cyc_q + CW'(1);
    cidx_d    = sample ? cidx_q + 2'd1 : cidx_q;

    col_hits  = 3'd0;
    row_first = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      col_hits = col_hits + {2'b0, ~row_s2_q[r]};
      if (!row_s2_q[r])
        row_first = 2'(r);
    end

    // Hit count saturates at 2: anything past one key is a reject
    sum      = {1'b0, hits_q} + col_hits;
    hits_new = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    code_new = (hits_q == 2'd0 && col_hits != 3'd0)
             ? key_map(cidx_q, row_first) : code_q;

    res.valid = (hits_new == 2'd1);
    res.code  = code_new;

    hits_d = hits_q;
    code_d = code_q;
    if (scan_done) begin
      hits_d = 2'd0;
      code_d = 4'h0;
    end else if (sample) begin
      hits_d = hits_new;
      code_d = code_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      cyc_q    <= '0;
      cidx_q   <= 2'd0;
      hits_q   <= 2'd0;
      code_q   <= 4'h0;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
      cyc_q    <= cyc_d;
      cidx_q   <= cidx_d;
      hits_q   <= hits_d;
      code_q   <= code_d;
    end
  end

  assign col = ~(4'b0001 << cidx_q);

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .REPEAT_SCANS   (REPEAT_SCANS)
  ) u_debounce (
    .clk            (clk),
    .rst_n          (rst_n),
    .scan_done      (scan_done),
    .res            (res),
    .dec            (dec),
    .button_pressed (button_pressed)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad model.
// Follows KEYPAD_REPEAT_EN for the auto-repeat expectations.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  dec;
  logic        button_pressed;
  logic [15:0] held = 16'h0;
  int          checks = 0;
  int          errors = 0;

`ifdef KEYPAD_REPEAT_EN
  localparam logic REP = 1'b1;
`else
  localparam logic REP = 1'b0;
`endif

  keypad_scanner #(
    .COL_CYCLES     (4),
    .DEBOUNCE_SCANS (3),
    .REPEAT_SCANS   (5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .row            (row),
    .col            (col),
    .dec            (dec),
    .button_pressed (button_pressed)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] key_pos(input int k);
    case (k)
      4'h1: return 4'b00_00;  4'h4: return 4'b00_01;
      4'h7: return 4'b00_10;  4'h0: return 4'b00_11;
      4'h2: return 4'b01_00;  4'h5: return 4'b01_01;
      4'h8: return 4'b01_10;  4'hF: return 4'b01_11;
      4'h3: return 4'b10_00;  4'h6: return 4'b10_01;
      4'h9: return 4'b10_10;  4'hE: return 4'b10_11;
      4'hA: return 4'b11_00;  4'hB: return 4'b11_01;
      4'hC: return 4'b11_10;  default: return 4'b11_11;
    endcase
  endfunction

  always_comb begin
    logic [3:0] p;
    row = 4'hF;
    for (int k = 0; k < 16; k++) begin
      p = key_pos(k);
      if (held[k] && col[p[3:2]] == 1'b0)
        row[p[1:0]] = 1'b0;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_col", col, 4'b1110);
    chk("rst_dec", dec, 4'h0);
    chk("rst_bp", {3'b0, button_pressed}, 4'h0);

    // Hold '5' across reset release
    held = 16'h0020;
    @(negedge clk) rst_n = 1'b1;
    clks(32);
    chk("k5_scan2", {3'b0, button_pressed}, 4'h0);
    clks(15);
    chk("k5_pre", {3'b0, button_pressed}, 4'h0);
    clks(1);
    chk("k5_bp", {3'b0, button_pressed}, 4'h1);
    chk("k5_dec", dec, 4'h5);
    held = 16'h0;
    clks(47);
    chk("k5_rel_pre", {3'b0, button_pressed}, 4'h1);
    clks(1);
    chk("k5_rel_bp", {3'b0, button_pressed}, 4'h0);
    chk("k5_rel_dec", dec, 4'h5);

    // Bouncing '9'
    for (int i = 0; i < 8; i++) begin
      held = (i % 2 == 0) ? 16'h0200 : 16'h0;
      clks(16);
      chk("bounce9", {3'b0, button_pressed}, 4'h0);
    end
    held = 16'h0;
    clks(48);
    chk("bounce9_end", {3'b0, button_pressed}, 4'h0);

    // '1' and '2' together, then only '1'
    held = 16'h0006;
    clks(64);
    chk("multi_bp", {3'b0, button_pressed}, 4'h0);
    held = 16'h0002;
    clks(32);
    chk("k1_pre", {3'b0, button_pressed}, 4'h0);
    clks(16);
    chk("k1_bp", {3'b0, button_pressed}, 4'h1);
    chk("k1_dec", dec, 4'h1);
    held = 16'h0;
    clks(48);
    chk("k1_rel", {3'b0, button_pressed}, 4'h0);

    // A accepted, then B with no gap
    held = 16'h0400;
    clks(48);
    chk("kA_bp", {3'b0, button_pressed}, 4'h1);
    chk("kA_dec", dec, 4'hA);
    held = 16'h0800;
    clks(32);
    chk("AB_hold", {3'b0, button_pressed}, 4'h1);
    clks(16);
    chk("AB_rel_bp", {3'b0, button_pressed}, 4'h0);
    chk("AB_rel_dec", dec, 4'hA);
    clks(32);
    chk("AB_wait", {3'b0, button_pressed}, 4'h0);
    clks(16);
    chk("kB_bp", {3'b0, button_pressed}, 4'h1);
    chk("kB_dec", dec, 4'hB);

    // Reset in the middle of the col2 dwell
    clks(9);
    chk("mid_col2", col, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_col", col, 4'b1110);
    chk("mrst_dec", dec, 4'h0);
    chk("mrst_bp", {3'b0, button_pressed}, 4'h0);

    // Hold '7' from release: acceptance, then repeat (if built in)
    held = 16'h0080;
    @(negedge clk) rst_n = 1'b1;
    clks(3);
    chk("restart_c0", col, 4'b1110);
    clks(1);
    chk("restart_c1", col, 4'b1101);
    clks(44);
    chk("k7_bp", {3'b0, button_pressed}, 4'h1);
    chk("k7_dec", dec, 4'h7);
    clks(64);
    chk("k7_s7", {3'b0, button_pressed}, 4'h1);
    clks(16);
    chk("k7_s8", {3'b0, button_pressed}, {3'b0, !REP});
    clks(15);
    chk("k7_s8_end", {3'b0, button_pressed}, {3'b0, !REP});
    clks(1);
    chk("k7_s9", {3'b0, button_pressed}, 4'h1);
    chk("k7_s9_dec", dec, 4'h7);
    clks(80);
    chk("k7_s14", {3'b0, button_pressed}, {3'b0, !REP});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
